// File: rtl/issue_ctrl.sv
// Dual-issue scheduler between the IF/ID instruction buffer and the ID stage.
// Launch flags are combinational from the two head entries; SYSTEM/FENCE drain and flush blanking are tracked by a small FSM.
module issue_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_flag,
    input  logic             id_stall,
    input  logic             slot0_valid,
    input  logic [31:0]      slot0_inst,
    input  logic             slot1_valid,
    input  logic [31:0]      slot1_inst,
    output logic             launch_flag1,
    output logic             launch_flag2,
    output logic             serial_busy,
    output logic [CNT_W-1:0] dual_cnt,
    output logic [CNT_W-1:0] single_cnt
);

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

    localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SERIAL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    typedef struct packed {
        logic       uses_rs1;
        logic       uses_rs2;
        logic       writes_rd;
        logic       mem;
        logic       muldiv;
        logic       ctrl;
        logic       serial;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t       d;
        logic [6:0] op;
        op         = inst[6:0];
        d.rd       = inst[11:7];
        d.rs1      = inst[19:15];
        d.rs2      = inst[24:20];
        d.uses_rs1 = (op != OPC_LUI) && (op != OPC_AUIPC) && (op != OPC_JAL);
        d.uses_rs2 = (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
        d.writes_rd = (inst[11:7] != 5'd0) && (op != OPC_STORE) && (op != OPC_BRANCH);
        d.mem      = (op == OPC_LOAD) || (op == OPC_STORE);
        d.muldiv   = (op == OPC_OP) && (inst[31:25] == 7'b0000001);
        d.ctrl     = (op == OPC_BRANCH) || (op == OPC_JAL) || (op == OPC_JALR);
        d.serial   = (op == OPC_SYSTEM) || (op == OPC_MISCMEM);
        return d;
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_drain_cnt;
    logic [3:0] w_drain_nxt;
    dec_t       w_d0;
    dec_t       w_d1;
    logic       w_issue_ok;
    logic       w_raw;
    logic       w_pair_block;

    assign w_d0 = decode(slot0_inst);
    assign w_d1 = decode(slot1_inst);

    // Intra-pair hazards that force slot1 to wait a cycle
    always_comb begin
        w_raw = 1'b0;
        w_pair_block = 1'b0;
        if (w_d0.writes_rd) begin
            w_raw = (w_d1.uses_rs1 && (w_d1.rs1 == w_d0.rd)) ||
                    (w_d1.uses_rs2 && (w_d1.rs2 == w_d0.rd));
        end else begin
            w_raw = 1'b0;
        end
        w_pair_block = w_raw || (w_d0.mem && w_d1.mem) || (w_d0.muldiv && w_d1.muldiv) ||
                       w_d0.ctrl || w_d0.serial || w_d1.serial;
    end

    // Launch gating
    always_comb begin
        w_issue_ok   = (r_state == ST_RUN) && !rst && !branch_flag && !id_stall;
        launch_flag1 = 1'b0;
        launch_flag2 = 1'b0;
        if (w_issue_ok && slot0_valid) begin
            launch_flag1 = 1'b1;
            launch_flag2 = slot1_valid && !w_pair_block;
        end else begin
            launch_flag1 = 1'b0;
            launch_flag2 = 1'b0;
        end
        serial_busy = (r_state == ST_SERIAL) && !rst;
    end

    // Next-state: flush dominates, then drain/serialise progression
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        if (branch_flag) begin
            w_state_nxt = ST_FLUSH;
            w_drain_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (launch_flag1 && w_d0.serial) begin
                        w_state_nxt = ST_SERIAL;
                        w_drain_nxt = DRAIN_INIT;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_SERIAL: begin
                    if (r_drain_cnt == 4'd1) begin
                        w_state_nxt = ST_RUN;
                        w_drain_nxt = 4'd0;
                    end else begin
                        w_drain_nxt = r_drain_cnt - 4'd1;
                    end
                end
                ST_FLUSH: begin
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_drain_nxt = 4'd0;
                end
            endcase
        end
    end

    // State and drain counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Issue statistics, free-running and wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            dual_cnt   <= {CNT_W{1'b0}};
            single_cnt <= {CNT_W{1'b0}};
        end else if (launch_flag2) begin
            dual_cnt   <= dual_cnt + CNT_ONE;
        end else if (launch_flag1) begin
            single_cnt <= single_cnt + CNT_ONE;
        end
    end

endmodule
